// File: rtl/time_unit_cnt_pkg.sv
// Shared types and constants for the modulo-N time-unit counter and its BCD decoder.
// Optional alarm feature is enabled by defining TIME_UNIT_CNT_ALARM_EN.
package time_cnt_pkg;

  typedef logic [3:0] bcd_t;

  localparam int MAX_MODULUS   = 100;
  localparam int HOUR12_OFFSET = 12;
  localparam int BCD_MAX       = 99;

  // Display path width: wide enough to hold 99 and any CW-bit count.
  function automatic int disp_width(input int cw);
    return (cw > 7) ? cw : 7;
  endfunction

endpackage

// File: rtl/time_unit_cnt_if.sv
// Control/status bundle of one time_unit_cnt stage.
// Alarm signals exist only when TIME_UNIT_CNT_ALARM_EN is defined.
interface time_unit_cnt_if import time_cnt_pkg::*; #(
  parameter int CW = 5
);

  logic          EN;
  logic          INC;
  logic          DEC;
  logic          LD;
  logic [CW-1:0] LD_VAL;
  logic          MODE24;
  logic [CW-1:0] CNT;
  bcd_t          QH;
  bcd_t          QL;
  logic          PM;
  logic          CO;
`ifdef TIME_UNIT_CNT_ALARM_EN
  logic          AL_WE;
  logic [CW-1:0] AL_VAL;
  logic          ALARM;

  modport master (
    output EN, INC, DEC, LD, LD_VAL, MODE24, AL_WE, AL_VAL,
    input  CNT, QH, QL, PM, CO, ALARM
  );
  modport slave (
    input  EN, INC, DEC, LD, LD_VAL, MODE24, AL_WE, AL_VAL,
    output CNT, QH, QL, PM, CO, ALARM
  );
`else
  modport master (
    output EN, INC, DEC, LD, LD_VAL, MODE24,
    input  CNT, QH, QL, PM, CO
  );
  modport slave (
    input  EN, INC, DEC, LD, LD_VAL, MODE24,
    output CNT, QH, QL, PM, CO
  );
`endif

endinterface

// File: rtl/time_unit_cnt_bin2bcd.sv
// Combinational binary to two-digit BCD decoder for values 0..99.
// Anything above 99 decodes to 0/0 so no undefined digit ever reaches the display.
module bin2bcd_lut import time_cnt_pkg::*; #(
  parameter int CW = 7
) (
  input  logic [CW-1:0] BIN,
  output bcd_t          QH,
  output bcd_t          QL
);

  localparam int W = disp_width(CW);

  logic [W-1:0] bin_s;

  // Split the value into tens and units, blanking out-of-range codes.
  always_comb begin
    bin_s = W'(BIN);
    if (bin_s <= W'(BCD_MAX)) begin
      QH = bcd_t'(bin_s / W'(10));
      QL = bcd_t'(bin_s % W'(10));
    end else begin
      QH = 4'd0;
      QL = 4'd0;
    end
  end

endmodule

// File: rtl/time_unit_cnt.sv
// Modulo-MODULUS time-unit counter with load, up/down, carry-out and 12h/24h BCD display.
// Defining TIME_UNIT_CNT_ALARM_EN adds an alarm register and a registered ALARM pulse.
module time_unit_cnt import time_cnt_pkg::*; #(
  parameter int MODULUS   = 24,
  parameter int CW        = 5,
  parameter int HOUR_MODE = 1
) (
  input logic            CLK,
  input logic            RST,
  time_unit_cnt_if.slave bus
);

  localparam int            DW      = disp_width(CW);
  localparam logic [CW-1:0] MAX_CNT = CW'(MODULUS - 1);
  localparam bit            HOUR_EN = (HOUR_MODE != 0);

  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_nxt_s;
  logic          up_s;
  logic          mode12_s;
  logic [DW-1:0] cnt_ext_s;
  logic [DW-1:0] disp_s;

  assign up_s = bus.EN | bus.INC;

  // Next count: load beats counting; simultaneous up and down cancel.
  always_comb begin
    cnt_nxt_s = cnt_r;
    if (bus.LD) begin
      if (bus.LD_VAL <= MAX_CNT) begin
        cnt_nxt_s = bus.LD_VAL;
      end else begin
        cnt_nxt_s = cnt_r;
      end
    end else if (up_s && bus.DEC) begin
      cnt_nxt_s = cnt_r;
    end else if (up_s) begin
      if (cnt_r == MAX_CNT) begin
        cnt_nxt_s = {CW{1'b0}};
      end else begin
        cnt_nxt_s = cnt_r + CW'(1);
      end
    end else if (bus.DEC) begin
      if (cnt_r == {CW{1'b0}}) begin
        cnt_nxt_s = MAX_CNT;
      end else begin
        cnt_nxt_s = cnt_r - CW'(1);
      end
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // Count register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_r <= {CW{1'b0}};
    end else begin
      cnt_r <= cnt_nxt_s;
    end
  end

  // Displayed value: 12h mode shows 0 as 12 and folds the afternoon back to 1..11.
  always_comb begin
    cnt_ext_s = DW'(cnt_r);
    mode12_s  = HOUR_EN & ~bus.MODE24;
    if (cnt_r > MAX_CNT) begin
      disp_s = {DW{1'b0}};
    end else if (!mode12_s) begin
      disp_s = cnt_ext_s;
    end else if (cnt_ext_s == {DW{1'b0}}) begin
      disp_s = DW'(HOUR12_OFFSET);
    end else if (cnt_ext_s <= DW'(HOUR12_OFFSET)) begin
      disp_s = cnt_ext_s;
    end else begin
      disp_s = cnt_ext_s - DW'(HOUR12_OFFSET);
    end
  end

  bin2bcd_lut #(.CW(DW)) u_bcd (
    .BIN (disp_s),
    .QH  (bus.QH),
    .QL  (bus.QL)
  );

  assign bus.CNT = cnt_r;
  assign bus.PM  = mode12_s & (cnt_ext_s >= DW'(HOUR12_OFFSET));
  // Only the chained carry ripples; manual INC never disturbs the next stage.
  assign bus.CO  = bus.EN & ~bus.LD & ~bus.DEC & ~RST & (cnt_r == MAX_CNT);

`ifdef TIME_UNIT_CNT_ALARM_EN
  logic [CW-1:0] al_r;
  logic          alarm_r;
  logic          al_hit_s;

  // An alarm fires only when the chained EN carry lands on the alarm value.
  always_comb begin
    if (bus.EN && !bus.LD && !bus.DEC) begin
      al_hit_s = (cnt_nxt_s == al_r);
    end else begin
      al_hit_s = 1'b0;
    end
  end

  // Alarm register and one-cycle alarm pulse.
  always_ff @(posedge CLK) begin
    if (RST) begin
      al_r    <= {CW{1'b0}};
      alarm_r <= 1'b0;
    end else begin
      if (bus.AL_WE && (bus.AL_VAL <= MAX_CNT)) begin
        al_r <= bus.AL_VAL;
      end else begin
        al_r <= al_r;
      end
      alarm_r <= al_hit_s;
    end
  end

  assign bus.ALARM = alarm_r;
`endif

endmodule
